// File: rtl/proc_pkg.sv
// Shared definitions for the control sequencer: opcode and register codes,
// ALU operation codes, FSM state encoding and small decode helpers.
package proc_pkg;

    // Opcodes, ir[11:8]
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_MOVE   = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_SUB    = 4'h3;
    localparam logic [3:0] OP_INC    = 4'h4;
    localparam logic [3:0] OP_LOADM  = 4'h5;
    localparam logic [3:0] OP_STOREM = 4'h6;
    localparam logic [3:0] OP_JMPZ   = 4'h7;
    localparam logic [3:0] OP_JMP    = 4'h8;
    localparam logic [3:0] OP_END    = 4'hF;

    // Register codes shared by wr_sel and bus_sel
    localparam logic [3:0] REG_SP  = 4'b0001;
    localparam logic [3:0] REG_MAR = 4'b0100;
    localparam logic [3:0] REG_MDR = 4'b0101;
    localparam logic [3:0] REG_PR1 = 4'b0110;
    localparam logic [3:0] REG_PR2 = 4'b0111;
    localparam logic [3:0] REG_PR3 = 4'b1000;
    localparam logic [3:0] REG_COL = 4'b1001;
    localparam logic [3:0] REG_ROW = 4'b1010;
    localparam logic [3:0] REG_R1  = 4'b1011;
    localparam logic [3:0] REG_R2  = 4'b1100;

    // ALU operations
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_INC  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC1  = 3'd4,
        ST_EXEC2  = 3'd5,
        ST_MEM    = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    function automatic logic is_legal_dst(input logic [3:0] code);
        case (code)
            REG_SP, REG_MAR, REG_MDR, REG_PR1, REG_PR2,
            REG_PR3, REG_COL, REG_ROW, REG_R1, REG_R2: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_for_op(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_INC:  return ALU_INC;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// mem_wait_timer: down-counter bounding how long the sequencer waits for a
// DRAM acknowledge.
//   clk, rst  clock and synchronous active-high reset
//   clear     reload the counter (asserted on the cycle entering MEM)
//   enable    count down (asserted while in MEM)
//   expired   terminal count reached: this is the last allowed wait cycle
module mem_wait_timer
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Loaded with TIMEOUT-1 so the count reads zero in the TIMEOUT-th wait cycle.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute micro-sequencer in front of the
// register-write decoder.
//   clk, rst            clock, synchronous active-high reset
//   start               launch from IDLE or HALT (clears done/err, pc=0)
//   iram_data           instruction read data, valid the cycle after iram_rd
//   z_flag, dram_ack    ALU zero flag, DRAM transfer complete
//   pc, iram_rd, ir     IRAM address, read strobe, instruction register
//   wr_sel, en_op, en_out   decoder destination select and strobes
//   bus_sel, alu_op     read-bus source and ALU operation
//   dram_rd, dram_wr    DRAM requests, held until ack or timeout
//   busy, done, err     status; done/err are sticky until the next start
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH1 | iram_rd asserted with pc as address
// FETCH2 | capture instruction, advance pc
// DECODE | dispatch on opcode; jumps, END and illegal codes resolve here
// EXEC1  | wr_sel/bus_sel/alu_op presented, en_op asserted
// EXEC2  | en_out asserted, one write strobe
// MEM    | DRAM request held until ack or timeout
// HALT   | stopped after END, illegal code or timeout
module control_sequencer
    import proc_pkg::*;
#(
    parameter int INSTR_W     = 12,
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] iram_data,
    input  logic               z_flag,
    input  logic               dram_ack,
    output logic [PC_W-1:0]    pc,
    output logic               iram_rd,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         wr_sel,
    output logic               en_op,
    output logic               en_out,
    output logic [3:0]         bus_sel,
    output logic [2:0]         alu_op,
    output logic               dram_rd,
    output logic               dram_wr,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [3:0]         wr_sel_q, wr_sel_d;
    logic [3:0]         bus_sel_q, bus_sel_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               iram_rd_q, iram_rd_d;
    logic               en_op_q, en_op_d;
    logic               en_out_q, en_out_d;
    logic               dram_rd_q, dram_rd_d;
    logic               dram_wr_q, dram_wr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               timer_clear;
    logic               timer_expired;

    logic [3:0]         opcode;
    logic [3:0]         dst_code;
    logic [3:0]         src_code;
    logic [PC_W-1:0]    jmp_target;

    assign opcode     = ir_q[INSTR_W-1 -: 4];
    assign dst_code   = ir_q[7:4];
    assign src_code   = ir_q[3:0];
    assign jmp_target = ir_q[PC_W-1:0];

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (state_q == ST_MEM),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        wr_sel_d    = wr_sel_q;
        bus_sel_d   = bus_sel_q;
        alu_op_d    = alu_op_q;
        done_d      = done_q;
        err_d       = err_q;
        timer_clear = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    pc_d    = '0;
                    state_d = ST_FETCH1;
                end
            end
            ST_FETCH1: state_d = ST_FETCH2;
            ST_FETCH2: begin
                ir_d    = iram_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_NOP: state_d = ST_FETCH1;
                    OP_END: begin
                        done_d  = 1'b1;
                        state_d = ST_HALT;
                    end
                    OP_JMP: begin
                        pc_d    = jmp_target;
                        state_d = ST_FETCH1;
                    end
                    OP_JMPZ: begin
                        if (z_flag) begin
                            pc_d = jmp_target;
                        end
                        state_d = ST_FETCH1;
                    end
                    OP_MOVE, OP_ADD, OP_SUB, OP_INC: begin
                        if (is_legal_dst(dst_code)) begin
                            wr_sel_d  = dst_code;
                            bus_sel_d = src_code;
                            alu_op_d  = alu_for_op(opcode);
                            state_d   = ST_EXEC1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end
                    end
                    OP_LOADM: begin
                        timer_clear = 1'b1;
                        state_d     = ST_MEM;
                    end
                    OP_STOREM: begin
                        // MDR drives the read bus for the whole write request.
                        timer_clear = 1'b1;
                        bus_sel_d   = REG_MDR;
                        state_d     = ST_MEM;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_EXEC1: state_d = ST_EXEC2;
            ST_EXEC2: state_d = ST_FETCH1;
            ST_MEM: begin
                // An ack in the final wait cycle takes priority over the timeout.
                if (dram_ack) begin
                    if (opcode == OP_LOADM) begin
                        wr_sel_d  = REG_MDR;
                        bus_sel_d = src_code;
                        alu_op_d  = ALU_PASS;
                        state_d   = ST_EXEC1;
                    end else begin
                        state_d = ST_FETCH1;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with it.
        iram_rd_d = (state_d == ST_FETCH1);
        en_op_d   = (state_d == ST_EXEC1);
        en_out_d  = (state_d == ST_EXEC2);
        dram_rd_d = (state_d == ST_MEM) && (opcode == OP_LOADM);
        dram_wr_d = (state_d == ST_MEM) && (opcode == OP_STOREM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            wr_sel_q  <= 4'b0000;
            bus_sel_q <= 4'b0000;
            alu_op_q  <= ALU_PASS;
            iram_rd_q <= 1'b0;
            en_op_q   <= 1'b0;
            en_out_q  <= 1'b0;
            dram_rd_q <= 1'b0;
            dram_wr_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            wr_sel_q  <= wr_sel_d;
            bus_sel_q <= bus_sel_d;
            alu_op_q  <= alu_op_d;
            iram_rd_q <= iram_rd_d;
            en_op_q   <= en_op_d;
            en_out_q  <= en_out_d;
            dram_rd_q <= dram_rd_d;
            dram_wr_q <= dram_wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign pc      = pc_q;
    assign iram_rd = iram_rd_q;
    assign ir      = ir_q;
    assign wr_sel  = wr_sel_q;
    assign en_op   = en_op_q;
    assign en_out  = en_out_q;
    assign bus_sel = bus_sel_q;
    assign alu_op  = alu_op_q;
    assign dram_rd = dram_rd_q;
    assign dram_wr = dram_wr_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. A program-level model walks each
// IRAM program instruction by instruction and queues the externally visible
// events (fetch, register write, DRAM transfer, halt); a monitor turns DUT
// outputs into the same events and compares them in order.
module tb_control_sequencer;

    localparam int EV_FETCH = 0;
    localparam int EV_WRITE = 1;
    localparam int EV_MEMRD = 2;
    localparam int EV_MEMWR = 3;
    localparam int EV_HALT  = 4;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int gap;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] iram_data = '0;
    logic        z_flag = 1'b0;
    logic        dram_ack = 1'b0;
    logic [7:0]  pc;
    logic        iram_rd;
    logic [11:0] ir;
    logic [3:0]  wr_sel;
    logic        en_op;
    logic        en_out;
    logic [3:0]  bus_sel;
    logic [2:0]  alu_op;
    logic        dram_rd;
    logic        dram_wr;
    logic        busy;
    logic        done;
    logic        err;

    control_sequencer #(
        .INSTR_W     (12),
        .PC_W        (8),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .iram_data (iram_data),
        .z_flag    (z_flag),
        .dram_ack  (dram_ack),
        .pc        (pc),
        .iram_rd   (iram_rd),
        .ir        (ir),
        .wr_sel    (wr_sel),
        .en_op     (en_op),
        .en_out    (en_out),
        .bus_sel   (bus_sel),
        .alu_op    (alu_op),
        .dram_rd   (dram_rd),
        .dram_wr   (dram_wr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
        end
    endtask

    // IRAM: data valid one cycle after the read strobe.
    logic [11:0] iram [256];
    always @(posedge clk) begin
        if (iram_rd) iram_data <= iram[pc];
    end

    // DRAM responder: latency L acks in the L-th request cycle, 0 never acks.
    int lat_arr[$];
    int lat_q[$];
    int cur_lat = 1;
    int req_cnt = 0;
    always @(negedge clk) begin
        if (dram_rd || dram_wr) begin
            if (req_cnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            req_cnt++;
            dram_ack = (cur_lat != 0) && (req_cnt == cur_lat);
        end else begin
            req_cnt  = 0;
            dram_ack = 1'b0;
        end
    end

    ev_t exp_q[$];

    function automatic ev_t mk(input int k, input int a, input int b, input int c, input int g);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.gap = g;
        return e;
    endfunction

    function automatic bit legal_dst(input int d);
        return (d == 1) || (d >= 4 && d <= 12);
    endfunction

    // Instruction-level model of one program run from pc=0.
    task automatic build_expect(input bit zf);
        int  p   = 0;
        int  li  = 0;
        bit  fin = 0;
        for (int step = 0; step < 300 && !fin; step++) begin
            logic [11:0] ins;
            int op, dst, src, tgt, lat;
            exp_q.push_back(mk(EV_FETCH, p, 0, 0, -1));
            ins = iram[p];
            op  = int'(ins[11:8]);
            dst = int'(ins[7:4]);
            src = int'(ins[3:0]);
            tgt = int'(ins[7:0]);
            p   = (p + 1) % 256;
            case (op)
                0: ;
                15: begin exp_q.push_back(mk(EV_HALT, 1, 0, 0, -1)); fin = 1; end
                8: p = tgt;
                7: if (zf) p = tgt;
                1, 2, 3, 4: begin
                    // MOVE pass(0), ADD 1, SUB 2, INC 3
                    if (legal_dst(dst)) exp_q.push_back(mk(EV_WRITE, dst, src, op - 1, 4));
                    else begin exp_q.push_back(mk(EV_HALT, 0, 1, 0, -1)); fin = 1; end
                end
                5, 6: begin
                    lat = (li < lat_arr.size()) ? lat_arr[li] : 1;
                    li++;
                    if (lat == 0) begin
                        exp_q.push_back(mk(op == 5 ? EV_MEMRD : EV_MEMWR, 16, 1, 0, -1));
                        exp_q.push_back(mk(EV_HALT, 0, 1, 0, -1));
                        fin = 1;
                    end else begin
                        exp_q.push_back(mk(op == 5 ? EV_MEMRD : EV_MEMWR, lat, 1, 0, -1));
                        if (op == 5) exp_q.push_back(mk(EV_WRITE, 5, -1, 0, -1));
                    end
                end
                default: begin exp_q.push_back(mk(EV_HALT, 0, 1, 0, -1)); fin = 1; end
            endcase
        end
    endtask

    task automatic got(input ev_t act);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: actual kind %0d a=%0h, required no event", act.kind, act.a);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", act.kind, e.kind);
        if (act.kind != e.kind) return;
        case (e.kind)
            EV_FETCH: begin
                chk("fetch_pc", act.a, e.a);
                chk("fetch_done_err", act.b, e.b);
            end
            EV_WRITE: begin
                chk("write_wr_sel", act.a, e.a);
                if (e.b >= 0) chk("write_bus_sel", act.b, e.b);
                chk("write_alu_op", act.c, e.c);
                if (e.gap >= 0) chk("write_en_out_latency", act.gap, e.gap);
            end
            EV_MEMRD: chk("dram_rd_cycles", act.a, e.a);
            EV_MEMWR: begin
                chk("dram_wr_cycles", act.a, e.a);
                chk("dram_wr_bus_sel_mdr", act.b, e.b);
            end
            default: begin
                chk("halt_done", act.a, e.a);
                chk("halt_err", act.b, e.b);
                chk("halt_strobes", act.c, e.c);
            end
        endcase
    endtask

    // Monitor
    bit   mon_en = 0;
    int   cyc = 0, last_fetch = 0, rd_cnt = 0, wr_cnt = 0, halt_seen = 0;
    bit   wr_bus_ok = 1;
    logic prev_rd = 0, prev_wr = 0, prev_busy = 0;
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (prev_rd && !dram_rd) got(mk(EV_MEMRD, rd_cnt, 1, 0, -1));
            if (prev_wr && !dram_wr) got(mk(EV_MEMWR, wr_cnt, int'(wr_bus_ok), 0, -1));
            if (prev_busy && !busy) begin
                got(mk(EV_HALT, int'(done), int'(err),
                       int'({iram_rd, en_op, en_out, dram_rd, dram_wr}), -1));
                halt_seen++;
            end
            if (iram_rd) begin
                got(mk(EV_FETCH, int'(pc), int'({done, err}), 0, -1));
                last_fetch = cyc;
            end
            if (en_out) got(mk(EV_WRITE, int'(wr_sel), int'(bus_sel), int'(alu_op), cyc - last_fetch));
        end
        if (dram_rd) rd_cnt++; else rd_cnt = 0;
        if (dram_wr) begin
            wr_cnt++;
            if (bus_sel !== 4'b0101) wr_bus_ok = 0;
        end else begin
            wr_cnt    = 0;
            wr_bus_ok = 1;
        end
        prev_rd   = dram_rd;
        prev_wr   = dram_wr;
        prev_busy = busy;
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) iram[i] = 12'hF00;
        lat_arr.delete();
    endtask

    task automatic run_prog(input bit zf);
        int h0;
        int budget;
        exp_q.delete();
        build_expect(zf);
        lat_q  = lat_arr;
        z_flag = zf;
        h0     = halt_seen;
        @(negedge clk);
        start  = 1'b1;
        budget = 0;
        while (halt_seen == h0 && budget < 2000) begin
            @(negedge clk);
            budget++;
            // start pulses while busy must be ignored
            if (start) start = 1'b0;
            else if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        start = 1'b0;
        if (halt_seen == h0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: actual no halt after %0d cycles, required halt", budget);
        end
        @(negedge clk);
        chk("leftover_expected_events", exp_q.size(), 0);
    endtask

    int legal_list[10] = '{1, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    int bad_dst[6]     = '{0, 2, 3, 13, 14, 15};
    int lat_pick[8]    = '{1, 2, 3, 4, 5, 16, 3, 0};

    task automatic gen_random_prog();
        int k;
        int r;
        logic [7:0] t;
        clear_prog();
        k = $urandom_range(3, 12);
        for (int a = 0; a < k; a++) begin
            r = $urandom_range(0, 99);
            t = 8'($urandom_range(a + 1, k));
            if (r < 40)
                iram[a] = {4'($urandom_range(1, 4)), 4'(legal_list[$urandom_range(0, 9)]), 4'($urandom_range(0, 15))};
            else if (r < 48) iram[a] = {4'h0, 8'($urandom_range(0, 255))};
            else if (r < 58) iram[a] = {4'h8, t};
            else if (r < 68) iram[a] = {4'h7, t};
            else if (r < 78) iram[a] = {4'h5, 8'($urandom_range(0, 255))};
            else if (r < 88) iram[a] = {4'h6, 8'($urandom_range(0, 255))};
            else if (r < 94)
                iram[a] = {4'($urandom_range(1, 4)), 4'(bad_dst[$urandom_range(0, 5)]), 4'($urandom_range(0, 15))};
            else iram[a] = {4'($urandom_range(9, 14)), 8'($urandom_range(0, 255))};
        end
        for (int i = 0; i < 8; i++) lat_arr.push_back(lat_pick[$urandom_range(0, 7)]);
    endtask

    initial begin
        int n;
        clear_prog();
        repeat (3) @(negedge clk);
        chk("rst_pc", int'(pc), 0);
        chk("rst_ir", int'(ir), 0);
        chk("rst_wr_sel", int'(wr_sel), 0);
        chk("rst_bus_sel", int'(bus_sel), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_strobes", int'({iram_rd, en_op, en_out, dram_rd, dram_wr}), 0);
        chk("rst_flags", int'({busy, done, err}), 0);
        rst = 1'b0;
        mon_en = 1;

        clear_prog(); iram[0] = 12'h1B6;                 run_prog(0);  // MOVE R1<-PR1, END
        clear_prog(); iram[0] = 12'h825;                 run_prog(0);  // JMP 0x25
        clear_prog(); iram[0] = 12'h725;                 run_prog(0);  // JMPZ not taken
        clear_prog(); iram[0] = 12'h725;                 run_prog(1);  // JMPZ taken
        clear_prog(); iram[0] = 12'h5B6; lat_arr = '{3}; run_prog(0);  // LOADM, ack after 3
        clear_prog(); iram[0] = 12'h600; lat_arr = '{0}; run_prog(0);  // STOREM timeout
        clear_prog(); iram[0] = 12'h600; lat_arr = '{16}; run_prog(0); // ack in last cycle
        clear_prog(); iram[0] = 12'hA00;                 run_prog(0);  // illegal opcode
        clear_prog(); iram[0] = 12'h123;                 run_prog(0);  // illegal MOVE dst
        clear_prog(); iram[0] = 12'h2C1; iram[1] = 12'h3B2; iram[2] = 12'h4A0;
        run_prog(0);                                                   // err cleared, ADD/SUB/INC

        // Reset in EXEC1
        mon_en = 0;
        clear_prog(); iram[0] = 12'h1B6;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!en_op && n < 20) begin @(negedge clk); n++; end
        chk("reached_exec1", int'(en_op), 1);
        chk("pc_before_rst", int'(pc), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec1_en_op_en_out", int'({en_op, en_out}), 0);
        chk("rst_exec1_pc", int'(pc), 0);
        chk("rst_exec1_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1;

        for (int i = 0; i < 40; i++) begin
            gen_random_prog();
            run_prog(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
